// File: rtl/processor_pkg.sv
// processor_pkg: shared state encoding and default widths for the memory port arbiter
package processor_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_D  = 2'd2
    } arb_state_e;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of fetch arbitrations lost to data
module arb_starve_ctr #(
    parameter int STARVE_MAX = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic sat
);
    localparam int W = $clog2(STARVE_MAX + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign sat = cnt_q == W'(STARVE_MAX);
    always_comb cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, with bounded fetch starvation
module mem_port_arbiter
    import processor_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LW = $clog2(MEM_LAT + 1);
    arb_state_e state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic last, free, starved, if_win, d_win;
    // the data-return cycle doubles as an arbitration cycle for back-to-back reads
    assign last   = lat_cnt_q == LW'(1);
    assign free   = state_q == ST_IDLE || last;
    assign if_win = reset && free && if_req && (!d_req || starved);
    assign d_win  = reset && free && d_req && !if_win;
    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign mem_re    = if_win || (d_win && !d_we);
    assign mem_we    = d_win && d_we;
    assign mem_addr  = !reset ? '0 : if_win ? if_addr : d_win ? d_addr : mem_addr_q;
    assign mem_wdata = (d_win && d_we) ? d_wdata : mem_wdata_q;
    assign if_valid  = state_q == ST_RD_IF && last;
    assign d_valid   = state_q == ST_RD_D && last;
    assign if_rdata  = if_valid ? mem_rdata : if_rdata_q;
    assign d_rdata   = d_valid ? mem_rdata : d_rdata_q;
    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clock(clock),
        .reset(reset),
        .clr  (if_win),
        .inc  (if_req && d_win),
        .sat  (starved)
    );
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        if (if_win) begin
            state_d   = ST_RD_IF;
            lat_cnt_d = LW'(MEM_LAT);
        end else if (d_win && !d_we) begin
            state_d   = ST_RD_D;
            lat_cnt_d = LW'(MEM_LAT);
        end else if (free) begin
            state_d   = ST_IDLE;
            lat_cnt_d = '0;
        end else begin
            lat_cnt_d = lat_cnt_q - LW'(1);
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
            if_rdata_q  <= if_rdata;
            d_rdata_q   <= d_rdata;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the processor's single-port memory between the fetch stage (instruction reads) and the execute stage (load/store data access). It sits between the pipeline controller and the memory. It grants one access at a time, tracks the memory read latency, and returns read data with a valid pulse. A bounded-starvation rule guarantees fetch progress under back-to-back data traffic.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MEM_LAT, 1, memory read latency in cycles (≥1)
- STARVE_MAX, 2, consecutive lost fetch arbitrations before fetch gets priority (≥1)

- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held high with stable if_addr until granted
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  fetch granted this cycle
- if_rdata  out  DATA_W  instruction byte, qualified by if_valid
- if_valid  out  1  one-cycle pulse, fetch read data ready
- d_req  in  1  data request; held high with stable d_we/d_addr/d_wdata until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle
- d_rdata  out  DATA_W  load data, qualified by d_valid
- d_valid  out  1  one-cycle pulse, load data ready
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_re

## Operation
- States: IDLE, RD_IF (fetch read outstanding), RD_D (load outstanding).
- Port free when state is IDLE, or when the state is RD_* and the latency counter is on its last cycle (the data-return cycle).
- Arbitration happens in the free cycle only:
  - Data wins by default.
  - Fetch wins if only if_req is high, or if starve_cnt == STARVE_MAX.
- Grant cycle:
  - Combinationally assert the winner's gnt.
  - Drive mem_addr from the winner.
  - Load: mem_re=1. Store: mem_we=1, mem_wdata=d_wdata.
- Store completes in the grant cycle. No valid pulse. Next state is IDLE, so the port is free next cycle.
- Read grant loads lat_cnt = MEM_LAT and enters RD_IF or RD_D. lat_cnt decrements each cycle.
- When lat_cnt reaches 1, the block pulses the matching *_valid and drives *_rdata = mem_rdata. The other rdata output holds its last value.
- A new grant may issue in that same return cycle (back-to-back). With no new grant, the next state is IDLE.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments, saturating, in each free cycle where if_req=1 and d wins.
  - Clears on if_gnt.
  - Holds otherwise.
- With no requests in a free cycle, all strobes and grants are 0 and mem_addr holds its previous value.
- Reset (asynchronous, any time, including mid-read):
  - state=IDLE, lat_cnt=0, starve_cnt=0.
  - Any outstanding read is discarded and no valid pulse follows.
  - if_gnt, d_gnt, if_valid, d_valid, mem_re and mem_we are 0 (all registered and combinational outputs gated to 0 while reset is low).
  - if_rdata, d_rdata, mem_addr and mem_wdata are 0.

## Timing
- Read: grant at cycle t, valid pulse at t+MEM_LAT. With MEM_LAT=1, the next grant is possible at t+1.
- Store: grant and write at cycle t. Next grant is possible at t+1.
- Maximum fetch wait under continuous d_req: STARVE_MAX data accesses.
- Simultaneous if_req and d_req with starve_cnt < STARVE_MAX: d_gnt=1, if_gnt=0.
- A requester dropping req before gnt is a protocol violation. Behaviour is unspecified and the bench flags it with an assertion.

## Structure
- Shared package (processor_pkg): state encoding localparams ST_IDLE, ST_RD_IF, ST_RD_D; default ADDR_W/DATA_W.
- Single module. An optional sub-module arb_starve_ctr holds the saturating starvation counter with clear/inc; inline is acceptable.
- Outputs: grant and strobe logic is combinational from registered state plus req. valid and rdata are registered or combinational on lat_cnt==1; choose one and keep the t+MEM_LAT latency exact.

## Test plan
- **Reset:** reset low for 3 cycles, then high. All outputs are 0 and state is IDLE. if_req=1 with if_addr=0x00 gives if_gnt at the first free cycle and if_valid with if_rdata=mem[0x00] one cycle later (MEM_LAT=1).
- **Collision:** if_req=1 @0x10 and d_req=1 load @0x80 in the same cycle. d_gnt first, d_valid with mem[0x80] next cycle, if_gnt in that same cycle, if_valid the cycle after.
- **Starvation:** d_req held high with 4 back-to-back stores to 0x40..0x43 and if_req=1 @0x05, STARVE_MAX=2. Sequence is d, d, if, d, d. Memory 0x40..0x43 is written in order.
- **Latency:** MEM_LAT=3, load @0x20 granted at t. d_valid is exactly at t+3. No grants at t+1 and t+2 despite if_req=1. if_gnt at t+3.
- **Reset mid-read:** MEM_LAT=3, fetch granted at t, reset pulsed low at t+1. No if_valid at t+3. starve_cnt=0 and state=IDLE after release.
- **Store/load ordering:** store 0xA5 to 0x30 then load 0x30 back-to-back. d_valid carries d_rdata=0xA5, mem_we for exactly one cycle.
